// File: rtl/inv_pipe_pkg.sv
// Shared constants, types and helpers for the inv_pipe masked-inversion pipeline.
// The stage struct is parametrised by width, so it is provided as a typedef macro.
`ifndef INV_PIPE_PKG_SV
`define INV_PIPE_PKG_SV

`define INV_PIPE_STAGE_T(w) struct packed { logic valid; logic [(w)-1:0] data; }

package inv_pipe_pkg;

  localparam int unsigned XFER_CNT_W = 16;

  // Fill bit for the mask reset value: every bit inverts out of reset.
  localparam logic MASK_RST = 1'b1;

  function automatic logic [XFER_CNT_W-1:0] sat_inc(input logic [XFER_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`endif

// File: rtl/inv_pipe_stage.sv
// One pipeline slot of inv_pipe: a valid bit plus data word, loaded when en is high.
// Synchronous active-high reset clears both fields.
module inv_pipe_stage
  import inv_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  typedef `INV_PIPE_STAGE_T(WIDTH) stage_t;

  stage_t slot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q <= '0;
    end else if (en) begin
      slot_q.valid <= d_valid;
      slot_q.data  <= d_data;
    end
  end

  assign q_valid = slot_q.valid;
  assign q_data  = slot_q.data;

endmodule

// File: rtl/inv_pipe.sv
// Pipelined, maskable inverter with valid/ready handshakes and full backpressure.
// Optional saturating output-transfer counter enabled by defining INV_PIPE_XFER_CNT_EN.
module inv_pipe
  import inv_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      a,
  input  logic                  a_valid,
  output logic                  a_ready,
  output logic [WIDTH-1:0]      y,
  output logic                  y_valid,
  input  logic                  y_ready,
  input  logic                  mask_we,
  input  logic [WIDTH-1:0]      mask_wdata,
  output logic [WIDTH-1:0]      mask,
  output logic [XFER_CNT_W-1:0] xfer_count
);

  logic [WIDTH-1:0]             mask_q;
  logic                         advance;
  logic [STAGES:0]              vld;
  logic [STAGES:0][WIDTH-1:0]   dat;

  // The whole pipe moves in lockstep; bubbles shift like data.
  assign advance = !vld[STAGES] || y_ready;
  assign a_ready = !rst && advance;

  // Slot 0 of the chain is the incoming word, inverted with the mask in use this cycle.
  assign vld[0] = a_valid;
  assign dat[0] = a ^ mask_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    inv_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (advance),
      .d_valid (vld[k]),
      .d_data  (dat[k]),
      .q_valid (vld[k+1]),
      .q_data  (dat[k+1])
    );
  end

  assign y       = dat[STAGES];
  assign y_valid = vld[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= {WIDTH{MASK_RST}};
    end else if (mask_we) begin
      mask_q <= mask_wdata;
    end
  end

  assign mask = mask_q;

`ifdef INV_PIPE_XFER_CNT_EN
  logic [XFER_CNT_W-1:0] xfer_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q <= '0;
    end else if (y_valid && y_ready) begin
      xfer_cnt_q <= sat_inc(xfer_cnt_q);
    end
  end

  assign xfer_count = xfer_cnt_q;
`else
  assign xfer_count = '0;
`endif

endmodule
